// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - fetch PC register and I-cache request sequencer
//
// Holds the fetch PC, issues one block-aligned request per fetch block,
// captures the block returned by the I-cache and presents it to decode
// together with per-slot PCs. Backend redirects override every other event.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   redirect_valid/pc backend redirect and its target
//   pc_nxt            next fetch PC chosen by the downstream selector
//   ireq_valid/addr   I-cache request (block aligned), ireq_ready accepts it
//   iresp_valid/data  single-cycle I-cache response, slot 0 in the LSBs
//   out_valid/ready   fetch block handshake towards decode
//   out_instr         captured block instructions
//   out_pc            PC of each slot (base + 4*i)
//   validF            slot valid mask (slots before the entry point masked)
//   pcF               sequential successor of each slot (base + 4*(i+1))

module fetch_pc_reg #(
    parameter int                 FETCH_WIDTH = 2,
    parameter int                 XLEN        = 64,
    parameter logic [XLEN-1:0]    PC_RESET    = XLEN'(64'h8000_0000)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic [XLEN-1:0]             pc_nxt,
    output logic                        ireq_valid,
    output logic [XLEN-1:0]             ireq_addr,
    input  logic                        ireq_ready,
    input  logic                        iresp_valid,
    input  logic [32*FETCH_WIDTH-1:0]   iresp_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [32*FETCH_WIDTH-1:0]   out_instr,
    output logic [XLEN*FETCH_WIDTH-1:0] out_pc,
    output logic [FETCH_WIDTH-1:0]      validF,
    output logic [XLEN*FETCH_WIDTH-1:0] pcF
);

    localparam int              BLK_BYTES = 4 * FETCH_WIDTH;
    localparam logic [XLEN-1:0] OFF_MASK  = XLEN'(BLK_BYTES - 1);
    localparam logic [XLEN-1:0] SLOT_MASK = XLEN'(FETCH_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t                      state;
    logic [XLEN-1:0]             pc;
    // Set when the outstanding request belongs to a PC that has since been
    // redirected away from; its response must be thrown away.
    logic                        drop;
    logic [32*FETCH_WIDTH-1:0]   instr_q;

    logic [XLEN-1:0]             base;
    logic [XLEN-1:0]             slot_k;

    assign base   = pc & ~OFF_MASK;
    // Entry slot inside the block; works for FETCH_WIDTH == 1 (mask is 0).
    assign slot_k = (pc >> 2) & SLOT_MASK;

    assign ireq_addr  = base;
    // Held low in the reset cycle even if the pre-reset state was REQ.
    assign ireq_valid = (state == ST_REQ) && !reset;
    assign out_valid  = (state == ST_HOLD);
    assign out_instr  = instr_q;

    always_comb begin
        out_pc = '0;
        pcF    = '0;
        validF = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            out_pc[i*XLEN +: XLEN] = base + XLEN'(4 * i);
            pcF[i*XLEN +: XLEN]    = base + XLEN'(4 * (i + 1));
            validF[i]              = out_valid && (XLEN'(i) >= slot_k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= PC_RESET;
            state   <= ST_REQ;
            drop    <= 1'b0;
            instr_q <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        // The old-PC request still goes out if accepted this
                        // cycle, so its response has to be discarded.
                        if (ireq_ready) begin
                            drop  <= 1'b1;
                            state <= ST_WAIT;
                        end
                    end else if (ireq_ready) begin
                        state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (iresp_valid) begin
                            // Response arriving now is for the old PC: the
                            // request is retired, nothing left to drop.
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (iresp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            instr_q <= iresp_data;
                            state   <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    // Redirect wins over a same-cycle decode handshake.
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= ST_REQ;
                    end else if (out_ready) begin
                        pc    <= pc_nxt;
                        state <= ST_REQ;
                    end
                end

                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_reg.sv
// tb/tb_fetch_pc_reg.sv - self-checking bench for fetch_pc_reg
module tb_fetch_pc_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic [63:0]  pc_nxt;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         ireq_ready;
    logic         iresp_valid;
    logic [63:0]  iresp_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_instr;
    logic [127:0] out_pc;
    logic [1:0]   validF;
    logic [127:0] pcF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_reg #(.FETCH_WIDTH(2), .XLEN(64), .PC_RESET(64'h8000_0000)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .pc_nxt(pc_nxt),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .validF(validF), .pcF(pcF)
    );

    typedef struct {
        logic [63:0]  instr;
        logic [127:0] opc;
        logic [127:0] pcf;
        logic [1:0]   vf;
    } exp_t;

    typedef struct {
        logic [63:0] start_pc;
        logic [63:0] data;
        logic [63:0] addr;
        logic [1:0]  vf;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic [63:0] pcf1;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [63:0] base, input logic [1:0] vf, input logic [63:0] d);
        exp_t e;
        e.instr = d;
        e.opc   = {base + 64'd4, base};
        e.pcf   = {base + 64'd8, base + 64'd4};
        e.vf    = vf;
        return e;
    endfunction

    // Wait (bounded) for a request, check its address, accept it.
    task automatic issue(input logic [63:0] addr, input string nm);
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ireq_valid === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk({nm, "_req_seen"}, 128'(seen), 128'd1);
        if (seen) begin
            chk({nm, "_req_addr"}, 128'(ireq_addr), 128'(addr));
            ireq_ready = 1'b1;
            tick();
            ireq_ready = 1'b0;
        end
    endtask

    task automatic respond(input logic [63:0] d, input bit push, input exp_t e);
        iresp_valid = 1'b1;
        iresp_data  = d;
        if (push) sb.push_back(e);
        tick();
        iresp_valid = 1'b0;
    endtask

    // Wait (bounded) for a block, compare against the scoreboard, accept it.
    task automatic drain(input logic [63:0] nxt, input string nm);
        bit seen = 0;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
            tick();
        end
        chk({nm, "_out_seen"}, 128'(seen), 128'd1);
        if (seen) begin
            if (sb.size() == 0) begin
                chk({nm, "_sb_nonempty"}, 128'd0, 128'd1);
            end else begin
                e = sb.pop_front();
                chk({nm, "_instr"}, 128'(out_instr), 128'(e.instr));
                chk({nm, "_out_pc"}, out_pc, e.opc);
                chk({nm, "_pcF"}, pcF, e.pcf);
                chk({nm, "_validF"}, 128'(validF), 128'(e.vf));
            end
            out_ready = 1'b1;
            pc_nxt    = nxt;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic redirect(input logic [63:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    vec_t vecs[5];
    exp_t e;
    exp_t none;

    initial begin
        vecs[0] = '{64'h8000_0104, 64'h1111_2222_3333_4444, 64'h8000_0100, 2'b10,
                    64'h8000_0100, 64'h8000_0104, 64'h8000_0108};
        vecs[1] = '{64'h0000_1000, 64'hAAAA_5555_0F0F_F0F0, 64'h0000_1000, 2'b11,
                    64'h0000_1000, 64'h0000_1004, 64'h0000_1008};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, 64'hFFFF_FFFF_FFFF_FFF8, 2'b10,
                    64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vecs[3] = '{64'h0000_0020, 64'h0123_4567_89AB_CDEF, 64'h0000_0020, 2'b11,
                    64'h0000_0020, 64'h0000_0024, 64'h0000_0028};
        vecs[4] = '{64'h1234_5678_9ABC_DEF4, 64'h0000_0013_0000_0073, 64'h1234_5678_9ABC_DEF0, 2'b10,
                    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF4, 64'h1234_5678_9ABC_DEF8};
        none = mk(64'd0, 2'b00, 64'd0);

        reset = 1'b1; redirect_valid = 0; redirect_pc = '0; pc_nxt = '0;
        ireq_ready = 0; iresp_valid = 0; iresp_data = '0; out_ready = 0;

        // Reset
        tick();
        @(negedge clk);
        chk("rst_ireq_valid_low", 128'(ireq_valid), 128'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_validF", 128'(validF), 128'd0);
        chk("rst_out_instr", 128'(out_instr), 128'd0);

        // Basic sequential fetch, minimum latency
        issue(64'h8000_0000, "basic0");
        respond(64'hCAFE_0001_BEEF_0000, 1, mk(64'h8000_0000, 2'b11, 64'hCAFE_0001_BEEF_0000));
        @(negedge clk);
        chk("basic0_latency_out_valid", 128'(out_valid), 128'd1);
        drain(64'h8000_0008, "basic0");
        issue(64'h8000_0008, "basic1");
        respond(64'h0000_0002_0000_0003, 1, mk(64'h8000_0008, 2'b11, 64'h0000_0002_0000_0003));
        drain(64'h8000_0010, "basic1");

        // Table: redirect in REQ (not accepted), then fetch one block
        for (int i = 0; i < 5; i++) begin
            redirect(vecs[i].start_pc);
            issue(vecs[i].addr, $sformatf("vec%0d", i));
            e.instr = vecs[i].data;
            e.opc   = {vecs[i].pc1, vecs[i].pc0};
            e.pcf   = {vecs[i].pcf1, vecs[i].pc1};
            e.vf    = vecs[i].vf;
            respond(vecs[i].data, 1, e);
            drain(64'h9000_0000, $sformatf("vec%0d", i));
        end

        // Redirect in WAIT, stale response three cycles later
        issue(64'h9000_0000, "waitredir");
        redirect(64'h8000_0200);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("waitredir_idle_out_valid", 128'(out_valid), 128'd0);
            chk("waitredir_idle_ireq", 128'(ireq_valid), 128'd0);
            tick();
        end
        respond(64'hBAD0_BAD0_BAD0_BAD0, 0, none);
        @(negedge clk);
        chk("waitredir_drop_out_valid", 128'(out_valid), 128'd0);
        issue(64'h8000_0200, "waitredir_new");
        respond(64'h2000_0000_2000_0001, 1, mk(64'h8000_0200, 2'b11, 64'h2000_0000_2000_0001));
        drain(64'h8000_0300, "waitredir_new");

        // Redirect coincident with response
        issue(64'h8000_0300, "coinc");
        iresp_valid = 1'b1; iresp_data = 64'hBAD1_BAD1_BAD1_BAD1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0400;
        tick();
        iresp_valid = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_out_valid", 128'(out_valid), 128'd0);
        issue(64'h8000_0400, "coinc_new");
        respond(64'h4000_0004_4000_0000, 1, mk(64'h8000_0400, 2'b11, 64'h4000_0004_4000_0000));
        drain(64'h8000_0020, "coinc_new");

        // HOLD stall for five cycles
        issue(64'h8000_0020, "stall");
        e = mk(64'h8000_0020, 2'b11, 64'h5555_6666_7777_8888);
        respond(64'h5555_6666_7777_8888, 1, e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_no_ireq", 128'(ireq_valid), 128'd0);
            chk("stall_instr", 128'(out_instr), 128'(e.instr));
            chk("stall_out_pc", out_pc, e.opc);
            chk("stall_validF", 128'(validF), 128'(e.vf));
            tick();
        end
        drain(64'h8000_0040, "stall");
        issue(64'h8000_0040, "stall_next");

        // Redirect in HOLD with out_ready high: block not delivered
        respond(64'hBAD2_BAD2_BAD2_BAD2, 0, none);
        @(negedge clk);
        chk("holdredir_out_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        pc_nxt    = 64'h7777_0000;
        redirect(64'h8000_0500);
        out_ready = 1'b0;
        @(negedge clk);
        chk("holdredir_dropped", 128'(out_valid), 128'd0);
        issue(64'h8000_0500, "holdredir_new");
        respond(64'h0500_0500_0500_0500, 1, mk(64'h8000_0500, 2'b11, 64'h0500_0500_0500_0500));
        drain(64'h8000_0600, "holdredir_new");

        // Redirect in REQ while the request is accepted: response dropped
        @(negedge clk);
        chk("reqacc_ireq_valid", 128'(ireq_valid), 128'd1);
        ireq_ready = 1'b1;
        redirect(64'h8000_0700);
        ireq_ready = 1'b0;
        respond(64'hBAD3_BAD3_BAD3_BAD3, 0, none);
        @(negedge clk);
        chk("reqacc_out_valid", 128'(out_valid), 128'd0);
        issue(64'h8000_0700, "reqacc_new");
        respond(64'h0700_0700_0700_0700, 1, mk(64'h8000_0700, 2'b11, 64'h0700_0700_0700_0700));
        drain(64'h8000_0800, "reqacc_new");

        // Reset while in HOLD
        issue(64'h8000_0800, "rsthold");
        respond(64'hBAD4_BAD4_BAD4_BAD4, 0, none);
        @(negedge clk);
        chk("rsthold_in_hold", 128'(out_valid), 128'd1);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("rsthold_ireq_low", 128'(ireq_valid), 128'd0);
        chk("rsthold_out_valid", 128'(out_valid), 128'd0);
        chk("rsthold_validF", 128'(validF), 128'd0);
        chk("rsthold_instr", 128'(out_instr), 128'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rsthold_ireq_valid", 128'(ireq_valid), 128'd1);
        chk("rsthold_ireq_addr", 128'(ireq_addr), 128'h8000_0000);

        chk("sb_empty", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
